serial_reversal_deserializer: RTL and testbench



---
 rtl/serial_reversal_deserializer_pkg.sv | 20 ++
 rtl/serial_reversal_deserializer_bit_shift_collector.sv | 72 +++++++
 rtl/serial_reversal_deserializer.sv | 95 +++++++++
 tb/tb_serial_reversal_deserializer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_reversal_deserializer_pkg.sv
// Shared constants and phase type for the serial bit-reversal deserializer.
// Holds only state-free definitions; every file imports it.
package serial_reversal_deserializer_pkg;

    localparam int unsigned K_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(K_DEFAULT);

    // Collection phase decoded from the bit counter.
    typedef enum logic {
        PH_COLLECT = 1'b0,
        PH_LAST    = 1'b1
    } phase_e;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned bit_cnt_width(input int unsigned k);
        return (k < 2) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/serial_reversal_deserializer_bit_shift_collector.sv
// Shift register and bit counter that assemble K serial bits into a word.
// word_done/next_word announce a completed word in the cycle its last bit fires.
module bit_shift_collector
    import serial_reversal_deserializer_pkg::*;
#(
    parameter int unsigned K       = K_DEFAULT,
    parameter bit          REVERSE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_fire,
    input  logic         in_bit,
    output logic         last_bit,
    output logic         word_done,
    output logic [K-1:0] next_word
);

    localparam int unsigned    CW       = bit_cnt_width(K);
    localparam logic [CW-1:0]  LAST_CNT = CW'(K - 1);

    logic [K-1:0]  shreg_q;
    logic [K-1:0]  shreg_d;
    logic [K-1:0]  shifted;
    logic [CW-1:0] bit_cnt_q;
    logic [CW-1:0] bit_cnt_d;
    phase_e        phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Shifted value already includes the current bit so a completing word
    // can be handed to the holding register in the same cycle.
    always_comb begin
        shifted = shreg_q;
        if (REVERSE) begin
            shifted = {shreg_q[K-2:0], in_bit};
        end else begin
            shifted = {in_bit, shreg_q[K-1:1]};
        end
    end

    always_comb begin
        phase = (bit_cnt_q == LAST_CNT) ? PH_LAST : PH_COLLECT;
    end

    always_comb begin
        last_bit  = (phase == PH_LAST);
        word_done = in_fire & last_bit;
        next_word = shifted;
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (clear) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (in_fire) begin
            shreg_d   = shifted;
            bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_reversal_deserializer.sv
// Serial-to-word receiver: collects K bits, delivers them in reversed or natural
// order through a single holding register with valid/ready on both sides.
module serial_reversal_deserializer
    import serial_reversal_deserializer_pkg::*;
#(
    parameter int unsigned K       = K_DEFAULT,
    parameter bit          REVERSE = 1'b1,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [K-1:0]     out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] words_out
);

    logic             last_bit;
    logic             word_done;
    logic [K-1:0]     next_word;
    logic             in_fire;
    logic             out_fire;

    logic [K-1:0]     out_word_q;
    logic [K-1:0]     out_word_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic [CNT_W-1:0] words_out_q;
    logic [CNT_W-1:0] words_out_d;

    bit_shift_collector #(
        .K       (K),
        .REVERSE (REVERSE)
    ) u_collector (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_fire   (in_fire),
        .in_bit    (in_bit),
        .last_bit  (last_bit),
        .word_done (word_done),
        .next_word (next_word)
    );

    // Stall only the completing bit, and only if the held word is not leaving now.
    always_comb begin
        in_ready = !(last_bit & out_valid_q & !out_ready);
        in_fire  = in_valid & in_ready;
        out_fire = out_valid_q & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            words_out_q <= '0;
        end else begin
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            words_out_q <= words_out_d;
        end
    end

    // A completion in the same cycle as a delivery refills the register
    // back-to-back, keeping out_valid high.
    always_comb begin
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        words_out_d = words_out_q;
        if (clear) begin
            out_word_d  = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_fire) begin
                out_valid_d = 1'b0;
                words_out_d = words_out_q + 1'b1;
            end
            if (word_done) begin
                out_valid_d = 1'b1;
                out_word_d  = next_word;
            end
        end
    end

    always_comb begin
        out_word  = out_word_q;
        out_valid = out_valid_q;
        words_out = words_out_q;
    end

endmodule

// File: tb/tb_serial_reversal_deserializer.sv
// Directed bench: three instances (reversed, natural, 2-bit counter) share one
// stimulus stream; a vector table plus hand-written streaming/reset/wrap sequences.
module tb_serial_reversal_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;

    logic       rev_in_ready, nat_in_ready, w2_in_ready;
    logic [3:0] rev_word, nat_word, w2_word;
    logic       rev_valid, nat_valid, w2_valid;
    logic [7:0] rev_cnt, nat_cnt;
    logic [1:0] w2_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_reversal_deserializer #(.K(4), .REVERSE(1'b1), .CNT_W(8)) u_rev (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(rev_in_ready), .out_word(rev_word), .out_valid(rev_valid),
        .out_ready(out_ready), .words_out(rev_cnt)
    );

    serial_reversal_deserializer #(.K(4), .REVERSE(1'b0), .CNT_W(8)) u_nat (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(nat_in_ready), .out_word(nat_word), .out_valid(nat_valid),
        .out_ready(out_ready), .words_out(nat_cnt)
    );

    serial_reversal_deserializer #(.K(4), .REVERSE(1'b1), .CNT_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_bit(in_bit), .in_valid(in_valid),
        .in_ready(w2_in_ready), .out_word(w2_word), .out_valid(w2_valid),
        .out_ready(out_ready), .words_out(w2_cnt)
    );

    typedef struct {
        logic       bit_i;
        logic       valid;
        logic       ready;
        logic       clr;
        logic       exp_ir;
        logic       exp_ov;
        logic [3:0] exp_rev;
        logic [3:0] exp_nat;
        int         exp_words;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int b, input int v, input int r, input int c,
                       input int ir, input int ov, input int er, input int en, input int w);
        vec_t t;
        t.bit_i     = b[0];
        t.valid     = v[0];
        t.ready     = r[0];
        t.clr       = c[0];
        t.exp_ir    = ir[0];
        t.exp_ov    = ov[0];
        t.exp_rev   = er[3:0];
        t.exp_nat   = en[3:0];
        t.exp_words = w;
        vecs.push_back(t);
    endtask

    // Called at posedge+1: drive, check in_ready mid-cycle, clock, check outputs.
    task automatic drive(input logic b, input logic v, input logic r, input logic c);
        in_bit    = b;
        in_valid  = v;
        out_ready = r;
        clear     = c;
        #2;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_rev;
        logic [3:0] exp_nat;
        logic       b;
        int         wrap_seq[5];

        rst_n = 1'b0; clear = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        wrap_seq = '{1, 2, 3, 0, 1};

        // bits 1,0,1,1 ; backpressure A then 5 ; abort after 2 bits ; 0,1,(gap),1,0
        add(1,1,1,0, 1,0, 'h0,'h0, 0);
        add(0,1,1,0, 1,0, 'h0,'h0, 0);
        add(1,1,1,0, 1,0, 'h0,'h0, 0);
        add(1,1,1,0, 1,1, 'hB,'hD, 0);
        add(0,0,1,0, 1,0, 'hB,'hD, 1);
        add(1,1,0,0, 1,0, 'hB,'hD, 1);
        add(0,1,0,0, 1,0, 'hB,'hD, 1);
        add(1,1,0,0, 1,0, 'hB,'hD, 1);
        add(0,1,0,0, 1,1, 'hA,'h5, 1);
        add(0,1,0,0, 1,1, 'hA,'h5, 1);
        add(1,1,0,0, 1,1, 'hA,'h5, 1);
        add(0,1,0,0, 1,1, 'hA,'h5, 1);
        add(1,1,0,0, 0,1, 'hA,'h5, 1);
        add(1,1,0,0, 0,1, 'hA,'h5, 1);
        add(1,1,1,0, 1,1, 'h5,'hA, 2);
        add(0,0,1,0, 1,0, 'h5,'hA, 3);
        add(1,1,0,0, 1,0, 'h5,'hA, 3);
        add(1,1,0,0, 1,0, 'h5,'hA, 3);
        add(0,1,0,0, 1,0, 'h5,'hA, 3);
        add(0,1,0,0, 1,1, 'hC,'h3, 3);
        add(1,1,0,0, 1,1, 'hC,'h3, 3);
        add(1,1,0,0, 1,1, 'hC,'h3, 3);
        add(1,1,1,1, 1,0, 'h0,'h0, 3);
        add(0,1,1,0, 1,0, 'h0,'h0, 3);
        add(1,1,1,0, 1,0, 'h0,'h0, 3);
        add(1,0,1,0, 1,0, 'h0,'h0, 3);
        add(1,1,1,0, 1,0, 'h0,'h0, 3);
        add(0,1,1,0, 1,1, 'h6,'h6, 3);
        add(0,0,1,0, 1,0, 'h6,'h6, 4);

        step();
        chk("reset_in_ready", int'(rev_in_ready), 1);
        chk("reset_out_valid", int'(rev_valid), 0);
        chk("reset_out_word", int'(rev_word), 0);
        chk("reset_words_out", int'(rev_cnt), 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].bit_i, vecs[i].valid, vecs[i].ready, vecs[i].clr);
            chk($sformatf("v%0d_in_ready", i), int'(rev_in_ready), int'(vecs[i].exp_ir));
            chk($sformatf("v%0d_nat_in_ready", i), int'(nat_in_ready), int'(vecs[i].exp_ir));
            step();
            chk($sformatf("v%0d_out_valid", i), int'(rev_valid), int'(vecs[i].exp_ov));
            chk($sformatf("v%0d_rev_word", i), int'(rev_word), int'(vecs[i].exp_rev));
            chk($sformatf("v%0d_nat_word", i), int'(nat_word), int'(vecs[i].exp_nat));
            chk($sformatf("v%0d_words", i), int'(rev_cnt), vecs[i].exp_words);
            chk($sformatf("v%0d_w2_words", i), int'(w2_cnt), vecs[i].exp_words % 4);
        end

        // Streaming: 64 random bits, no stalls, one word every 4 cycles.
        exp_rev = '0;
        exp_nat = '0;
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom);
            exp_rev[3 - (i % 4)] = b;
            exp_nat[i % 4]       = b;
            drive(b, 1'b1, 1'b1, 1'b0);
            chk($sformatf("s%0d_in_ready", i), int'(rev_in_ready), 1);
            step();
            if (i % 4 == 3) begin
                chk($sformatf("s%0d_out_valid", i), int'(rev_valid), 1);
                chk($sformatf("s%0d_rev_word", i), int'(rev_word), int'(exp_rev));
                chk($sformatf("s%0d_nat_word", i), int'(nat_word), int'(exp_nat));
                chk($sformatf("s%0d_words", i), int'(rev_cnt), 4 + i / 4);
            end else begin
                chk($sformatf("s%0d_out_valid", i), int'(rev_valid), 0);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("stream_words_total", int'(rev_cnt), 20);
        chk("stream_valid_drained", int'(rev_valid), 0);

        // Asynchronous reset mid-word with a held word present.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            step();
        end
        chk("pre_reset_valid", int'(rev_valid), 1);
        chk("pre_reset_word", int'(rev_word), 'hF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(rev_valid), 0);
        chk("async_rst_word", int'(rev_word), 0);
        chk("async_rst_words", int'(rev_cnt), 0);
        chk("async_rst_nat_word", int'(nat_word), 0);
        chk("async_rst_w2_word", int'(w2_word), 0);
        chk("async_rst_w2_valid", int'(w2_valid), 0);
        chk("async_rst_in_ready", int'(w2_in_ready), 1);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;

        // Counter wrap on the 2-bit instance.
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) begin
                drive(1'(k + i), 1'b1, 1'b1, 1'b0);
                step();
            end
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            step();
            chk($sformatf("wrap%0d_w2_words", k), int'(w2_cnt), wrap_seq[k]);
            chk($sformatf("wrap%0d_rev_words", k), int'(rev_cnt), k + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
